// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the MEM-stage data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A nonzero mask decides the access size; otherwise the load type does.
    function automatic logic is_misaligned(input logic [3:0] mask,
                                           input logic [2:0] lt,
                                           input logic [1:0] off);
        logic word;
        logic half;
        if (mask != 4'b0000) begin
            word = (mask == MASK_W);
            half = (mask == MASK_H);
        end else begin
            half = (lt == LT_LH) || (lt == LT_LHU);
            word = !half && (lt != LT_LB) && (lt != LT_LBU);
        end
        return (word && (off != 2'b00)) || (half && off[0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Lane-selects a read word by byte offset and sign/zero-extends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] ext_data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        ext_data = w_shifted;
        case (load_type)
            LT_LB:   ext_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            LT_LBU:  ext_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            LT_LH:   ext_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            LT_LHU:  ext_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: ext_data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage req/ack data-memory access with store lane
//               alignment, load extension and pipeline stall. Define
//               MEM_TIMEOUT_EN to add the ack timeout and bus_fault output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cache_read_en_MEM,
    input  logic [3:0]      cache_write_en_MEM,
    input  logic [2:0]      load_type_MEM,
    input  logic [XLEN-1:0] addr_MEM,
    input  logic [XLEN-1:0] store_data_MEM,
    input  logic            flush_mem,
    input  logic            hold_mem,
    output logic            mem_req,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] load_data_MEM,
    output logic            stall_mem,
`ifdef MEM_TIMEOUT_EN
    output logic            bus_fault,
`endif
    output logic            misalign_fault
);

    logic [1:0]      state_q, state_d;
    logic            req_q, req_d;
    logic [3:0]      we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] ld_q, ld_d;
    logic            mis_q, mis_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      lt_q, lt_d;
    logic            is_load_q, is_load_d;
    logic [XLEN-1:0] ext_data;
    logic            op, is_store, misaligned, start, mis_hit, timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 32 : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    assign timeout   = (state_q == ST_REQ) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_fault = fault_q;
`else
    assign timeout   = 1'b0;
`endif

    assign is_store   = (cache_write_en_MEM != 4'b0000);
    assign op         = is_store || cache_read_en_MEM;
    assign misaligned = is_misaligned(cache_write_en_MEM, load_type_MEM, addr_MEM[1:0]);
    assign start      = (state_q == ST_IDLE) && op && !flush_mem && !misaligned;
    assign mis_hit    = (state_q == ST_IDLE) && op && !flush_mem && misaligned;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata     (mem_rdata),
        .offset    (off_q),
        .load_type (lt_q),
        .ext_data  (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (mem_ack || timeout) state_d = ST_DONE;
            ST_DONE: if (!hold_mem) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_mem = start || (state_q == ST_REQ);
    end

    always_comb begin
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ld_d      = ld_q;
        off_d     = off_q;
        lt_d      = lt_q;
        is_load_d = is_load_q;
        mis_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        fault_d   = 1'b0;
`endif
        if (start) begin
            req_d     = 1'b1;
            we_d      = is_store ? 4'(cache_write_en_MEM << addr_MEM[1:0]) : 4'b0000;
            addr_d    = {addr_MEM[XLEN-1:2], 2'b00};
            wdata_d   = store_data_MEM << {addr_MEM[1:0], 3'b000};
            off_d     = addr_MEM[1:0];
            lt_d      = load_type_MEM;
            is_load_d = !is_store;
`ifdef MEM_TIMEOUT_EN
            cnt_d     = '0;
`endif
        end else if (mis_hit) begin
            mis_d = 1'b1;
            ld_d  = '0;
        end
        if (state_q == ST_REQ) begin
            if (mem_ack) begin
                req_d = 1'b0;
                we_d  = 4'b0000;
                if (is_load_q) ld_d = ext_data;
            end else if (timeout) begin
                req_d = 1'b0;
                we_d  = 4'b0000;
                ld_d  = '0;
`ifdef MEM_TIMEOUT_EN
                fault_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            we_q      <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_q      <= '0;
            mis_q     <= 1'b0;
            off_q     <= 2'b00;
            lt_q      <= LT_LW;
            is_load_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ld_q      <= ld_d;
            mis_q     <= mis_d;
            off_q     <= off_d;
            lt_q      <= lt_d;
            is_load_q <= is_load_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
`endif
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign load_data_MEM  = ld_q;
    assign misalign_fault = mis_q;

endmodule

`default_nettype wire
